// File: rtl/jk_excitation_driver.sv
// Buffers target bits in a small FIFO and drives J/K so a downstream JK flop's Q follows them.
// Define JKD_QCHECK_EN to add the q_fb/q_err downstream-Q checker.
module jk_excitation_driver #(
    parameter int DEPTH   = 4,
    parameter bit DC_FILL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tgt_valid,
    input  logic                       tgt_bit,
    output logic                       tgt_ready,
    input  logic                       drv_en,
    output logic                       j,
    output logic                       k,
    output logic                       drv_valid,
    output logic                       q_model,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
`ifdef JKD_QCHECK_EN
    input  logic                       q_fb,
    output logic                       q_err,
`endif
    output logic                       idle
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             t;

    // Ready uses the pre-edge count, so a full FIFO never accepts even when popping.
    assign tgt_ready = (fifo_count != FULL_CNT);
    assign push      = tgt_valid && tgt_ready;
    assign pop       = drv_en && (fifo_count != '0);
    assign t         = mem[rd_ptr];
    assign idle      = (fifo_count == '0) && !drv_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tgt_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            j          <= 1'b0;
            k          <= 1'b0;
            drv_valid  <= 1'b0;
            q_model    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            // Excitation: from Q=0 only J matters, from Q=1 only K matters.
            if (pop) begin
                j         <= q_model ? DC_FILL : t;
                k         <= q_model ? !t : DC_FILL;
                q_model   <= t;
                drv_valid <= 1'b1;
            end else begin
                j         <= 1'b0;
                k         <= 1'b0;
                drv_valid <= 1'b0;
            end
        end
    end

`ifdef JKD_QCHECK_EN
    logic chk;
    logic exp_q;

    // Downstream Q settles one edge after drv_valid, so compare on the edge after that.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk   <= 1'b0;
            exp_q <= 1'b0;
            q_err <= 1'b0;
        end else begin
            chk <= drv_valid;
            if (drv_valid) begin
                exp_q <= q_model;
            end
            if (chk) begin
                q_err <= q_err | (q_fb != exp_q);
            end
        end
    end
`endif

endmodule
